rand_request_arbiter: RTL and testbench
=======================================

Name: rand_request_arbiter

Overview:
- Shares one latch-on-rising-edge random generator (8-bit counter sampled on a rise pulse) between N_REQ game clients, e.g. enemy spawn X, spawn Y, gift drop and gift type.
- Grants requests round-robin, drives the generator's rise input and captures its output.
- Reduces the captured value into the granted client's range [0, limit] by sequential modulo folding, then returns the result with a one-cycle ack to that client.

Parameters:
- SIZE_BITS, 8: width of the random value and of each limit.
- N_REQ, 4: number of requesting clients.

Ports:
- clk  in  1: clock.
- resetN  in  1: reset, asynchronous, active-low.
- req  in  N_REQ: level request per client; held until that client's ack.
- limit  in  N_REQ*SIZE_BITS: packed inclusive upper bounds; client i uses bits [i*SIZE_BITS +: SIZE_BITS].
- rise_out  out  1: drives the generator's rise input.
- rand_in  in  SIZE_BITS: generator dout.
- ack  out  N_REQ: one-hot, one-cycle pulse to the served client.
- rand_out  out  SIZE_BITS: result; valid during the ack cycle, held until the next DONE.
- busy  out  1: high in every state except IDLE.

Behaviour:
- Reset values:
  - state = IDLE; rise_out = 0; ack = 0; rand_out = 0; busy = 0.
  - Round-robin pointer = N_REQ-1, so client 0 has first priority.
  - Work register and captured limit = 0.
- Reset mid-operation aborts the transaction: no ack is issued, and rise_out drops immediately.
- IDLE:
  - If any req bit is set, grant the first set bit searching from pointer+1 upward, modulo N_REQ.
  - Register the grant index and that client's limit (limit is sampled once, at grant).
  - Pointer <= grant index. Next state RISE.
- RISE: rise_out = 1 for exactly this one cycle. The generator latches its counter at the closing edge. Next state SAMPLE.
- SAMPLE: rise_out = 0. rand_in is valid this cycle; work <= rand_in. Next state FOLD.
- FOLD:
  - If work > L, then work <= work - (L+1) and stay in FOLD.
  - Otherwise rand_out <= work and go to DONE.
  - Compute L+1 in SIZE_BITS+1 bits. L = 2^SIZE_BITS-1 never folds. L = 0 always yields 0.
- DONE: ack[grant] = 1, all other ack bits 0. Next state IDLE.
- Latency: with req seen in IDLE at cycle 0, RISE is cycle 1, SAMPLE cycle 2, FOLD starts cycle 3, ack at cycle 4+k, where k = number of subtractions (k <= floor(rand_in/(L+1))).
- rise_out is low for at least one cycle (SAMPLE) between any two RISE cycles, which guarantees a clean rising edge at the generator every transaction.
- A client dropping req after grant does not cancel the transaction; its ack is still pulsed. Changes to a client's limit after grant are ignored.
- New requests arriving while busy wait. Back-to-back service: the IDLE cycle following DONE arbitrates again.
- Simultaneous requests: exactly one grant per transaction. A continuously requesting client is never starved; each waits at most N_REQ-1 transactions.
- Outputs ack and busy are decoded from the registered state only. rand_out is a register.

Decomposition:
- Package rand_arb_pkg holds:
  - the state enum (IDLE, RISE, SAMPLE, FOLD, DONE);
  - default constants RAND_SIZE_BITS = 8 and RAND_N_REQ = 4.
- Sub-module rr_arbiter (combinational round-robin pick from req and pointer, producing a one-hot grant and its index) is natural and separately testable.
- The FSM, fold datapath and pointer register stay in the top module.

Test Plan:
- Single request, rand_in = 42 in SAMPLE, limit0 = 99 -> rise_out high only in cycle 1, ack[0] in cycle 4, rand_out = 42.
- Folding: req0, limit0 = 99, rand_in = 250 -> work 250→150→50, ack[0] in cycle 6, rand_out = 50.
- Range extremes:
  - limit = 255, rand_in = 255 -> rand_out = 255, no fold, ack in cycle 4.
  - limit = 0, rand_in = 3 -> 3 folds, rand_out = 0, ack in cycle 7.
- Fairness: req = 4'b1111 held continuously, no folds -> acks in order 0,1,2,3,0 at cycles 4,9,14,19,24; rise_out low between successive RISE cycles.
- Reset mid-operation: assert resetN low during FOLD -> no ack; rise_out, busy and rand_out are 0 immediately. After release, req = 4'b0100 -> client 2 is served, pointer = 2.
- Request drop and limit change after grant: req1 drops and limit1 changes from 99 to 9 during SAMPLE, rand_in = 120 -> ack[1] still pulses, rand_out = 20 (the original limit 99 is used).

Source files
------------

// File: rtl/rand_request_arbiter_pkg.sv
// Shared types and defaults for the random-request arbiter slice.
// The state encodings are also exposed as fixed-width constants for older code that compares raw bits.
package rand_arb_pkg;

    localparam int RAND_SIZE_BITS = 8;
    localparam int RAND_N_REQ     = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RISE   = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_FOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        RISE   = ST_RISE,
        SAMPLE = ST_SAMPLE,
        FOLD   = ST_FOLD,
        DONE   = ST_DONE
    } rand_state_e;

    // Width needed to index n clients, kept at least 1 bit for the single-client case.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rand_request_arbiter_if.sv
// Client/generator bundle between the game clients, the random generator and the arbiter.
interface rand_request_arbiter_if #(
    parameter int SIZE_BITS = rand_arb_pkg::RAND_SIZE_BITS,
    parameter int N_REQ     = rand_arb_pkg::RAND_N_REQ
) ();

    logic [N_REQ-1:0]           req;
    logic [N_REQ*SIZE_BITS-1:0] limit;
    logic                       rise_out;
    logic [SIZE_BITS-1:0]       rand_in;
    logic [N_REQ-1:0]           ack;
    logic [SIZE_BITS-1:0]       rand_out;
    logic                       busy;

    modport master (
        output req, limit, rand_in,
        input  rise_out, ack, rand_out, busy
    );

    modport slave (
        input  req, limit, rand_in,
        output rise_out, ack, rand_out, busy
    );

endinterface

// File: rtl/rand_request_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr+1, wrapping modulo N_REQ.
module rr_arbiter
    import rand_arb_pkg::*;
#(
    parameter int N_REQ = RAND_N_REQ,
    parameter int IDX_W = idx_bits(RAND_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rand_request_arbiter.sv
// Shares one latch-on-rise random generator among N_REQ clients: round-robin grant,
// pulse rise, capture, fold into [0, limit] by repeated subtraction, then ack.
module rand_request_arbiter
    import rand_arb_pkg::*;
#(
    parameter int SIZE_BITS = RAND_SIZE_BITS,
    parameter int N_REQ     = RAND_N_REQ
) (
    input logic                   clk,
    input logic                   resetN,
    rand_request_arbiter_if.slave bus
);

    localparam int IDX_W = idx_bits(N_REQ);

    rand_state_e          state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic [N_REQ-1:0]     pick_grant;
    logic                 pick_any;
    logic [N_REQ-1:0]     grant_oh;
    logic [SIZE_BITS-1:0] lim_pick;
    logic [SIZE_BITS-1:0] lim_q;
    logic [SIZE_BITS-1:0] work;
    logic [SIZE_BITS-1:0] rand_q;
    logic [SIZE_BITS:0]   lim_p1;
    logic [SIZE_BITS-1:0] fold_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (bus.req),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        lim_pick = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) lim_pick = bus.limit[i*SIZE_BITS +: SIZE_BITS];
        end
    end

    // L+1 needs the extra bit so that a full-range limit cannot wrap to zero.
    assign lim_p1   = {1'b0, lim_q} + (SIZE_BITS+1)'(1);
    assign fold_nxt = SIZE_BITS'({1'b0, work} - lim_p1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            ptr      <= IDX_W'(N_REQ - 1);
            grant_oh <= '0;
            lim_q    <= '0;
            work     <= '0;
            rand_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_oh <= pick_grant;
                        lim_q    <= lim_pick;
                        ptr      <= pick_idx;
                        state    <= RISE;
                    end
                end
                RISE:   state <= SAMPLE;
                SAMPLE: begin
                    work  <= bus.rand_in;
                    state <= FOLD;
                end
                FOLD: begin
                    if (work > lim_q) begin
                        work <= fold_nxt;
                    end else begin
                        rand_q <= work;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rise_out = (state == RISE);
    assign bus.busy     = (state != IDLE);
    assign bus.ack      = (state == DONE) ? grant_oh : '0;
    assign bus.rand_out = rand_q;

endmodule

// File: tb/tb_rand_request_arbiter.sv
// Bench for rand_request_arbiter: directed cases plus random traffic against a
// reference that predicts grant order, result (r mod (L+1)) and ack latency.
module tb_rand_request_arbiter;

    localparam int SB = 8;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic resetN;

    rand_request_arbiter_if #(.SIZE_BITS(SB), .N_REQ(NR)) bus ();

    rand_request_arbiter #(.SIZE_BITS(SB), .N_REQ(NR)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_ptr = NR - 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r);
        for (int i = 1; i <= NR; i++) begin
            int c = (m_ptr + i) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_lim(input int i, input int v);
        bus.limit[i*SB +: SB] = SB'(v);
    endtask

    function automatic int get_lim(input int i);
        return int'(bus.limit[i*SB +: SB]);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Runs one transaction from the current negedge; base is 1 when the arbiter is still in DONE.
    task automatic serve(input string tag, input int idx, input int r, input int base,
                         input bit hold, input int perturb_at, input int new_lim);
        int  lim     = get_lim(idx);
        int  exp_v   = r % (lim + 1);
        int  exp_lat = base + 4 + r / (lim + 1);
        int  cyc      = 0;
        int  rise_cnt = 0;
        int  rise_at  = -1;
        bit  got      = 1'b0;
        m_ptr = idx;
        while (!got && cyc < base + 300) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == perturb_at) begin
                bus.req[idx] = 1'b0;
                set_lim(idx, new_lim);
            end
            if (bus.rise_out) begin
                rise_cnt++;
                if (rise_at < 0) rise_at = cyc;
            end
            if (bus.ack != '0) got = 1'b1;
        end
        check_eq({tag, ".ack"},      32'(bus.ack), 32'(1) << idx);
        check_eq({tag, ".rand_out"}, 32'(bus.rand_out), exp_v);
        check_eq({tag, ".latency"},  cyc, exp_lat);
        check_eq({tag, ".rise_at"},  rise_at, base + 1);
        check_eq({tag, ".rise_cnt"}, rise_cnt, 1);
        check_eq({tag, ".busy"},     32'(bus.busy), 1);
        if (!hold) bus.req[idx] = 1'b0;
    endtask

    initial begin
        int r;
        int base;
        resetN      = 1'b0;
        bus.req     = '0;
        bus.limit   = '0;
        bus.rand_in = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.ack",      32'(bus.ack), 0);
        check_eq("rst.busy",     32'(bus.busy), 0);
        check_eq("rst.rise",     32'(bus.rise_out), 0);
        check_eq("rst.rand_out", 32'(bus.rand_out), 0);
        resetN = 1'b1;
        idle(1);

        // Single request, no folding.
        set_lim(0, 99); bus.rand_in = 8'd42; bus.req = 4'b0001;
        serve("single", pick(bus.req), 42, 0, 1'b0, -1, 0);
        idle(1);

        // Two folds: 250 -> 150 -> 50.
        bus.rand_in = 8'd250; bus.req = 4'b0001;
        serve("fold", pick(bus.req), 250, 0, 1'b0, -1, 0);
        idle(1);

        // Full-range limit never folds.
        set_lim(0, 255); bus.rand_in = 8'd255; bus.req = 4'b0001;
        serve("lim255", pick(bus.req), 255, 0, 1'b0, -1, 0);
        idle(1);

        // Reset while folding aborts the transaction.
        set_lim(0, 0); bus.rand_in = 8'd200; bus.req = 4'b0001;
        repeat (5) @(negedge clk);
        check_eq("abort.busy_pre", 32'(bus.busy), 1);
        resetN = 1'b0;
        #1;
        check_eq("abort.rise",     32'(bus.rise_out), 0);
        check_eq("abort.busy",     32'(bus.busy), 0);
        check_eq("abort.rand_out", 32'(bus.rand_out), 0);
        check_eq("abort.ack",      32'(bus.ack), 0);
        bus.req = '0;
        m_ptr   = NR - 1;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort.ack_hold", 32'(bus.ack), 0);
        resetN = 1'b1;
        idle(1);
        check_eq("abort.idle", 32'(bus.busy), 0);

        set_lim(2, 77); bus.rand_in = 8'd30; bus.req = 4'b0100;
        serve("after_rst", pick(bus.req), 30, 0, 1'b0, -1, 0);
        idle(1);
        set_lim(3, 9); set_lim(0, 9); bus.rand_in = 8'd5; bus.req = 4'b1001;
        serve("ptr_after_rst", pick(bus.req), 5, 0, 1'b0, -1, 0);
        idle(1);

        // Fairness with every client requesting continuously.
        for (int i = 0; i < NR; i++) set_lim(i, 50);
        bus.rand_in = '0; bus.req = 4'b1111;
        base = 0;
        for (int t = 0; t < 5; t++) begin
            serve("fair", pick(bus.req), 0, base, 1'b1, -1, 0);
            base = 1;
        end
        bus.req = '0;
        idle(1);

        // Limit zero always yields zero.
        set_lim(0, 0); bus.rand_in = 8'd3; bus.req = 4'b0001;
        serve("lim0", pick(bus.req), 3, 0, 1'b0, -1, 0);
        idle(1);

        // Request drop and limit change after grant are ignored.
        set_lim(1, 99); bus.rand_in = 8'd120; bus.req = 4'b0010;
        serve("drop", pick(bus.req), 120, 0, 1'b0, 2, 9);
        idle(1);

        // Random back-to-back traffic.
        base = 0;
        repeat (40) begin
            bus.req = bus.req | NR'($urandom);
            if (bus.req == '0) bus.req[$urandom_range(0, NR-1)] = 1'b1;
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 3))
                    0:       set_lim(i, 0);
                    1:       set_lim(i, 255);
                    default: set_lim(i, int'($urandom_range(0, 255)));
                endcase
            end
            r = int'($urandom_range(0, 255));
            bus.rand_in = SB'(r);
            serve("rnd", pick(bus.req), r, base, 1'b0, -1, 0);
            base = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
